fs_error_diffuser: RTL

FS_ERROR_DIFFUSER -- requirements
Module: fs_error_diffuser

---
 rtl/fs_error_diffuser.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/fs_error_diffuser.sv
// fs_error_diffuser: Floyd-Steinberg 1-bit dithering of an 8-bit grey raster stream.
// Error terms are kept in 1/16 units in two ping-pong row buffers (current / next),
// plus a running carry for the pixel to the right.
module fs_error_diffuser #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int THRESH = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_pix,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_bit,
   output logic       m_eol,
   output logic       m_eof
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [8:0]    TH     = 9'(THRESH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Saturate a signed intermediate to the 8-bit pixel range.
   function automatic logic [7:0] clamp8(input logic signed [12:0] v);
      logic [7:0] r;
      if (v < 13'sd0) begin
         r = 8'd0;
      end else if (v > 13'sd255) begin
         r = 8'd255;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

   logic [2:0]          r_state;
   logic [XW-1:0]       r_x;
   logic [YW-1:0]       r_y;
   logic signed [12:0]  r_carry;
   logic                r_sel;
   logic signed [12:0]  r_ebuf [0:1][0:IMG_W-1];
   logic                r_m_valid;
   logic                r_m_bit;
   logic                r_m_eol;
   logic                r_m_eof;

   logic                w_s_ready;
   logic                w_xfer;
   logic                w_nsel;
   logic                w_last_row;
   logic                w_last;
   logic [XW-1:0]       w_xm1;
   logic [XW-1:0]       w_xp1;
   logic signed [12:0]  w_carry_use;
   logic signed [12:0]  w_sum;
   logic signed [12:0]  w_v;
   logic [7:0]          w_clamp;
   logic                w_bit;
   logic signed [12:0]  w_e;
   logic signed [12:0]  w_e3;
   logic signed [12:0]  w_e5;
   logic signed [12:0]  w_e7;

   assign w_s_ready  = (r_state == S_RUN) && (!r_m_valid || m_ready);
   assign w_xfer     = s_valid && w_s_ready;
   assign w_nsel     = ~r_sel;
   assign w_last_row = (r_y == Y_LAST);
   assign w_last     = (r_x == X_LAST) && w_last_row;
   assign w_xm1      = r_x - {{(XW-1){1'b0}}, 1'b1};
   assign w_xp1      = r_x + {{(XW-1){1'b0}}, 1'b1};

   assign s_ready = w_s_ready;
   assign m_valid = r_m_valid;
   assign m_bit   = r_m_bit;
   assign m_eol   = r_m_eol;
   assign m_eof   = r_m_eof;
   assign busy    = (r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done    = (r_state == S_DONE);

   // Quantise the current pixel with its diffused error and form the weighted error terms.
   always_comb begin
      w_carry_use = 13'sd0;
      w_sum       = 13'sd0;
      w_v         = 13'sd0;
      w_clamp     = 8'd0;
      w_bit       = 1'b0;
      w_e         = 13'sd0;
      if (r_x == {XW{1'b0}}) begin
         w_carry_use = 13'sd0;
      end else begin
         w_carry_use = r_carry;
      end
      w_sum   = w_carry_use + r_ebuf[r_sel][r_x];
      w_v     = $signed({5'd0, s_pix}) + (w_sum >>> 4);
      w_clamp = clamp8(w_v);
      w_bit   = ({1'b0, w_clamp} >= TH);
      if (w_bit) begin
         w_e = $signed({5'd0, w_clamp}) - 13'sd255;
      end else begin
         w_e = $signed({5'd0, w_clamp});
      end
   end

   assign w_e3 = (w_e <<< 1) + w_e;
   assign w_e5 = (w_e <<< 2) + w_e;
   assign w_e7 = (w_e <<< 3) - w_e;

   // Frame FSM with column/row counters, right-neighbour carry and buffer select.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_carry <= 13'sd0;
         r_sel   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CLEAR;
                  r_x     <= '0;
                  r_y     <= '0;
                  r_carry <= 13'sd0;
                  r_sel   <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (r_x == X_LAST) begin
                  r_x     <= '0;
                  r_state <= S_RUN;
               end else begin
                  r_x <= w_xp1;
               end
            end
            S_RUN: begin
               if (w_xfer) begin
                  r_carry <= w_e7;
                  if (r_x == X_LAST) begin
                     r_x   <= '0;
                     r_sel <= w_nsel;
                     if (w_last_row) begin
                        r_y     <= '0;
                        r_state <= S_DRAIN;
                     end else begin
                        r_y <= r_y + {{(YW-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     r_x <= w_xp1;
                  end
               end
            end
            S_DRAIN: begin
               if (r_m_valid && m_ready) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Row error buffers: zeroed during CLEAR; each consumed current entry is zeroed so the
   // buffer is clean when it becomes the next row; down-diffusion lands in the other buffer.
   always_ff @(posedge clk) begin
      if (rst_n && (r_state == S_CLEAR)) begin
         r_ebuf[0][r_x] <= 13'sd0;
         r_ebuf[1][r_x] <= 13'sd0;
      end else if (rst_n && w_xfer) begin
         r_ebuf[r_sel][r_x] <= 13'sd0;
         if (!w_last_row) begin
            r_ebuf[w_nsel][r_x] <= r_ebuf[w_nsel][r_x] + w_e5;
            if (r_x != {XW{1'b0}}) begin
               r_ebuf[w_nsel][w_xm1] <= r_ebuf[w_nsel][w_xm1] + w_e3;
            end
            if (r_x != X_LAST) begin
               r_ebuf[w_nsel][w_xp1] <= r_ebuf[w_nsel][w_xp1] + w_e;
            end
         end
      end
   end

   // Registered output stage: load on transfer, hold while stalled, retire when accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_bit   <= 1'b0;
         r_m_eol   <= 1'b0;
         r_m_eof   <= 1'b0;
      end else if (w_xfer) begin
         r_m_valid <= 1'b1;
         r_m_bit   <= w_bit;
         r_m_eol   <= (r_x == X_LAST);
         r_m_eof   <= w_last;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

endmodule
